pong_game_sequencer: RTL and testbench
======================================

PONG_GAME_SEQUENCER -- requirements
Module: pong_game_sequencer

Interface
REQ-001 The block SHALL have parameter SERVE_DELAY, default 25000000, meaning the number of clock cycles spent in SERVE before the ball is released (legal 1..2^TIMER_W-1).
REQ-002 The block SHALL have parameter TIMER_W, default 26, meaning the serve-timer width in bits.
REQ-003 The block SHALL have parameter WIN_SCORE, default 9, meaning the score that ends the game (legal 1..15).
REQ-004 The block SHALL have port CLOCK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port START, input, 1 bit: player start button level, already synchronous to CLOCK.
REQ-007 The block SHALL have port MISS_L, input, 1 bit: 1-cycle pulse, ball passed the left (human) paddle.
REQ-008 The block SHALL have port MISS_R, input, 1 bit: 1-cycle pulse, ball passed the right (AI) paddle.
REQ-009 The block SHALL have port BALL_ENABLE, output, 1 bit: ball may move; high only in PLAY.
REQ-010 The block SHALL have port BALL_SERVE, output, 1 bit: 1-cycle pulse, ball re-centred and launched.
REQ-011 The block SHALL have port SERVE_DIR, output, 1 bit: launch direction, 0 = toward left, 1 = toward right.
REQ-012 The block SHALL have port AI_ENABLE, output, 1 bit: the AI paddle tracks the ball; high in SERVE and PLAY.
REQ-013 The block SHALL have ports SCORE_L and SCORE_R, outputs, 4 bits each: left and right player scores.
REQ-014 The block SHALL have port GAME_OVER, output, 1 bit: high only in state OVER.
REQ-015 The block SHALL have port STATE, output, 3 bits: current state encoding, for debug/display.

Function
REQ-016 The block SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; encodings 5-7 SHALL go to IDLE on the next edge.
REQ-017 The block SHALL detect a START rising edge as START=1 while the registered previous START=0.
REQ-018 In IDLE or OVER, a START rising edge SHALL, on that edge: clear both scores, set SERVE_DIR=1, clear the timer and enter SERVE; START SHALL be ignored in all other states.
REQ-019 SERVE SHALL last exactly SERVE_DELAY cycles (timer counts 0..SERVE_DELAY-1), then enter PLAY.
REQ-020 BALL_SERVE SHALL be high only during the first cycle of each PLAY entry; BALL_ENABLE SHALL be high every PLAY cycle, including that one.
REQ-021 In PLAY, MISS_L alone SHALL increment SCORE_R and set SERVE_DIR=0; MISS_R alone SHALL increment SCORE_L and set SERVE_DIR=1; both cases SHALL take effect on the same edge that enters POINT.
REQ-022 In PLAY, MISS_L and MISS_R in the same cycle SHALL change neither score nor SERVE_DIR and SHALL enter POINT (replay).
REQ-023 POINT SHALL last one cycle, then enter OVER if either score equals WIN_SCORE, else enter SERVE with the timer cleared.
REQ-024 MISS_L and MISS_R SHALL be ignored outside PLAY.
REQ-025 Scores SHALL never exceed WIN_SCORE (no 4-bit wrap).
REQ-026 All outputs SHALL be registered or decoded only from state registers (no input-to-output combinational path).

Reset
REQ-027 RESET_N low SHALL immediately force state IDLE, timer 0, SCORE_L=SCORE_R=0, SERVE_DIR=1, BALL_ENABLE=BALL_SERVE=AI_ENABLE=GAME_OVER=0 and STATE=0, regardless of CLOCK.
REQ-028 The previous-START register SHALL reset to 1, so a button held through reset does not start a game until released and pressed again.
REQ-029 Reset asserted mid-SERVE or mid-PLAY SHALL abort with no BALL_SERVE pulse and no score change.

Verification (SERVE_DELAY=4, WIN_SCORE=2)
REQ-030 The bench SHALL check: reset, START 0->1 -> STATE=1 for exactly 4 cycles, then STATE=2 with BALL_SERVE=1 for one cycle, SERVE_DIR=1, AI_ENABLE=1.
REQ-031 The bench SHALL check: in PLAY, pulse MISS_R -> next cycle STATE=3, SCORE_L=1, SERVE_DIR=1; one cycle later STATE=1.
REQ-032 The bench SHALL check: in PLAY, MISS_L and MISS_R in the same cycle -> STATE=3, scores unchanged, then SERVE.
REQ-033 The bench SHALL check: two MISS_L points -> SCORE_R=2, STATE=4, GAME_OVER=1; further MISS pulses ignored; START edge -> scores 0, STATE=1.
REQ-034 The bench SHALL check: START held high through reset release -> stays IDLE; release then press -> SERVE.
REQ-035 The bench SHALL check: RESET_N low at timer=2 in SERVE -> all outputs at reset values asynchronously; no BALL_SERVE pulse observed.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer
//   Top-level game flow for a two-player pong: waits for a start press,
//   holds the ball for a serve delay, lets it play until a paddle misses,
//   tallies the point and ends the game at WIN_SCORE.
//
// Parameters
//   SERVE_DELAY : clock cycles spent in SERVE before launch (1..2^TIMER_W-1)
//   TIMER_W     : serve-timer width in bits
//   WIN_SCORE   : score that ends the game (1..15)
//
// Ports
//   CLOCK       in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   START       in   start button level (synchronous to CLOCK)
//   MISS_L      in   1-cycle pulse, ball passed the left (human) paddle
//   MISS_R      in   1-cycle pulse, ball passed the right (AI) paddle
//   BALL_ENABLE out  ball may move (PLAY only)
//   BALL_SERVE  out  1-cycle pulse on the first PLAY cycle
//   SERVE_DIR   out  launch direction, 0 = left, 1 = right
//   AI_ENABLE   out  AI paddle tracks ball (SERVE and PLAY)
//   SCORE_L     out  left player score
//   SCORE_R     out  right player score
//   GAME_OVER   out  high in OVER
//   STATE       out  current state encoding
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | power-up, waiting for a start press
// SERVE | ball parked at centre, counting down the serve delay
// PLAY  | ball in motion, watching for misses
// POINT | one-cycle pause after a miss, decides OVER vs next serve
// OVER  | a player reached WIN_SCORE, waiting for a new start press
module pong_game_sequencer #(
  parameter int SERVE_DELAY = 25000000,
  parameter int TIMER_W     = 26,
  parameter int WIN_SCORE   = 9
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       MISS_L,
  input  logic       MISS_R,
  output logic       BALL_ENABLE,
  output logic       BALL_SERVE,
  output logic       SERVE_DIR,
  output logic       AI_ENABLE,
  output logic [3:0] SCORE_L,
  output logic [3:0] SCORE_R,
  output logic       GAME_OVER,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_DELAY - 1);
  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         score_l_q, score_l_d;
  logic [3:0]         score_r_q, score_r_d;
  logic               serve_dir_q, serve_dir_d;
  logic               ball_serve_q, ball_serve_d;
  logic               start_prev_q;
  logic               start_rise;

  // start_prev resets high so a button held through reset is not a press
  assign start_rise = START & ~start_prev_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      serve_dir_q  <= 1'b1;
      ball_serve_q <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      serve_dir_q  <= serve_dir_d;
      ball_serve_q <= ball_serve_d;
      start_prev_q <= START;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_dir_d  = serve_dir_q;
    ball_serve_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_dir_d = 1'b1;
          timer_d     = '0;
          state_d     = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (timer_q == SERVE_LAST) begin
          state_d      = ST_PLAY;
          ball_serve_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      ST_PLAY: begin
        if (MISS_L && MISS_R) begin
          // simultaneous miss is a replay: no score, same direction
          state_d = ST_POINT;
        end else if (MISS_L) begin
          if (score_r_q < WIN) score_r_d = score_r_q + 4'd1;
          serve_dir_d = 1'b0;
          state_d     = ST_POINT;
        end else if (MISS_R) begin
          if (score_l_q < WIN) score_l_d = score_l_q + 4'd1;
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
        end
      end

      ST_POINT: begin
        if (score_l_q == WIN || score_r_q == WIN) begin
          state_d = ST_OVER;
        end else begin
          timer_d = '0;
          state_d = ST_SERVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign BALL_ENABLE = (state_q == ST_PLAY);
  assign BALL_SERVE  = ball_serve_q;
  assign SERVE_DIR   = serve_dir_q;
  assign AI_ENABLE   = (state_q == ST_SERVE) || (state_q == ST_PLAY);
  assign SCORE_L     = score_l_q;
  assign SCORE_R     = score_r_q;
  assign GAME_OVER   = (state_q == ST_OVER);
  assign STATE       = state_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// tb_pong_game_sequencer
//   Directed scenarios followed by a random run, all compared every cycle
//   against a rule-level model of the game flow.
module tb_pong_game_sequencer;

  localparam int SD  = 4;
  localparam int WIN = 2;

  logic       CLOCK;
  logic       RESET_N;
  logic       START;
  logic       MISS_L;
  logic       MISS_R;
  logic       BALL_ENABLE;
  logic       BALL_SERVE;
  logic       SERVE_DIR;
  logic       AI_ENABLE;
  logic [3:0] SCORE_L;
  logic [3:0] SCORE_R;
  logic       GAME_OVER;
  logic [2:0] STATE;

  pong_game_sequencer #(
    .SERVE_DELAY(SD),
    .TIMER_W(26),
    .WIN_SCORE(WIN)
  ) dut (
    .CLOCK(CLOCK),
    .RESET_N(RESET_N),
    .START(START),
    .MISS_L(MISS_L),
    .MISS_R(MISS_R),
    .BALL_ENABLE(BALL_ENABLE),
    .BALL_SERVE(BALL_SERVE),
    .SERVE_DIR(SERVE_DIR),
    .AI_ENABLE(AI_ENABLE),
    .SCORE_L(SCORE_L),
    .SCORE_R(SCORE_R),
    .GAME_OVER(GAME_OVER),
    .STATE(STATE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  // Game-level model: which phase we are in, how long the ball has been
  // parked, the two scores, the serve direction and the button history.
  int m_phase;       // 0 idle, 1 serve, 2 play, 3 point, 4 over
  int m_parked;      // cycles already spent in the current serve
  int m_sl, m_sr;
  int m_dir;
  int m_btn_prev;
  int m_launch;      // first cycle of play

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = 0;
    m_parked   = 0;
    m_sl       = 0;
    m_sr       = 0;
    m_dir      = 1;
    m_btn_prev = 1;
    m_launch   = 0;
  endtask

  task automatic model_step(input bit s, input bit l, input bit r);
    bit pressed;
    pressed    = s && (m_btn_prev == 0);
    m_btn_prev = s;
    m_launch   = 0;
    if (m_phase == 0 || m_phase == 4) begin
      if (pressed) begin
        m_sl = 0; m_sr = 0; m_dir = 1; m_parked = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_parked++;
      if (m_parked >= SD) begin
        m_phase  = 2;
        m_launch = 1;
      end
    end else if (m_phase == 2) begin
      if (l || r) begin
        if (l && !r) begin
          m_sr  = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
          m_dir = 0;
        end else if (r && !l) begin
          m_sl  = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
          m_dir = 1;
        end
        m_phase = 3;
      end
    end else if (m_phase == 3) begin
      if (m_sl == WIN || m_sr == WIN) m_phase = 4;
      else begin
        m_parked = 0;
        m_phase  = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  32'(STATE),       32'(m_phase));
    chk({tag, ".enable"}, 32'(BALL_ENABLE), 32'(m_phase == 2));
    chk({tag, ".serve"},  32'(BALL_SERVE),  32'(m_launch));
    chk({tag, ".dir"},    32'(SERVE_DIR),   32'(m_dir));
    chk({tag, ".ai"},     32'(AI_ENABLE),   32'(m_phase == 1 || m_phase == 2));
    chk({tag, ".score_l"},32'(SCORE_L),     32'(m_sl));
    chk({tag, ".score_r"},32'(SCORE_R),     32'(m_sr));
    chk({tag, ".over"},   32'(GAME_OVER),   32'(m_phase == 4));
  endtask

  // one clock: inputs applied before the edge, checked 1 time unit after it
  task automatic tick(input string tag, input bit s, input bit l, input bit r);
    START  = s;
    MISS_L = l;
    MISS_R = r;
    @(posedge CLOCK);
    model_step(s, l, r);
    #1;
    check_all(tag);
  endtask

  // asynchronous reset asserted between edges, held over two edges
  task automatic pulse_reset(input string tag);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge CLOCK);
    #1;
    chk({tag, ".no_serve0"}, 32'(BALL_SERVE), 32'd0);
    @(posedge CLOCK);
    #1;
    chk({tag, ".no_serve1"}, 32'(BALL_SERVE), 32'd0);
    check_all({tag, ".held"});
    RESET_N = 1'b1;
  endtask

  task automatic ride_serve(input string tag);
    for (int i = 0; i < SD; i++) tick(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int serve_cycles;
    START   = 1'b0;
    MISS_L  = 1'b0;
    MISS_R  = 1'b0;
    RESET_N = 1'b1;
    #1;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;

    // start edge -> SERVE for exactly SD cycles -> PLAY with a launch pulse
    tick("idle", 1'b0, 1'b0, 1'b0);
    tick("start", 1'b1, 1'b0, 1'b0);
    serve_cycles = 0;
    for (int i = 0; i < 20 && STATE == 3'd1; i++) begin
      serve_cycles++;
      tick("serve", 1'b0, 1'b0, 1'b0);
    end
    chk("serve_len", 32'(serve_cycles), 32'(SD));
    chk("launch_state", 32'(STATE), 32'd2);
    chk("launch_pulse", 32'(BALL_SERVE), 32'd1);
    chk("launch_dir", 32'(SERVE_DIR), 32'd1);
    chk("launch_ai", 32'(AI_ENABLE), 32'd1);
    tick("play", 1'b0, 1'b0, 1'b0);
    chk("pulse_once", 32'(BALL_SERVE), 32'd0);

    // right miss -> left point
    tick("miss_r", 1'b0, 1'b0, 1'b1);
    chk("miss_r_state", 32'(STATE), 32'd3);
    chk("miss_r_score", 32'(SCORE_L), 32'd1);
    tick("point", 1'b0, 1'b0, 1'b0);
    chk("point_to_serve", 32'(STATE), 32'd1);
    ride_serve("serve2");

    // simultaneous miss -> replay
    tick("both", 1'b0, 1'b1, 1'b1);
    chk("both_state", 32'(STATE), 32'd3);
    chk("both_score_l", 32'(SCORE_L), 32'd1);
    chk("both_score_r", 32'(SCORE_R), 32'd0);
    tick("both_point", 1'b0, 1'b0, 1'b0);
    chk("replay_serve", 32'(STATE), 32'd1);
    ride_serve("serve3");

    // two left misses -> right wins
    tick("miss_l1", 1'b0, 1'b1, 1'b0);
    chk("miss_l1_dir", 32'(SERVE_DIR), 32'd0);
    tick("point_l1", 1'b0, 1'b0, 1'b0);
    ride_serve("serve4");
    tick("miss_l2", 1'b0, 1'b1, 1'b0);
    tick("point_l2", 1'b0, 1'b0, 1'b0);
    chk("win_score_r", 32'(SCORE_R), 32'd2);
    chk("win_state", 32'(STATE), 32'd4);
    chk("win_over", 32'(GAME_OVER), 32'd1);
    tick("over_ml", 1'b0, 1'b1, 1'b0);
    tick("over_mr", 1'b0, 1'b0, 1'b1);
    tick("over_both", 1'b0, 1'b1, 1'b1);
    tick("restart", 1'b1, 1'b0, 1'b0);
    chk("restart_state", 32'(STATE), 32'd1);
    chk("restart_score_r", 32'(SCORE_R), 32'd0);
    tick("restart_hold", 1'b1, 1'b0, 1'b0);

    // START held through reset does not start a game
    pulse_reset("rst_held");
    for (int i = 0; i < 3; i++) tick("held_idle", 1'b1, 1'b0, 1'b0);
    chk("held_stays_idle", 32'(STATE), 32'd0);
    tick("release", 1'b0, 1'b0, 1'b0);
    tick("press", 1'b1, 1'b0, 1'b0);
    chk("press_serve", 32'(STATE), 32'd1);

    // reset at timer=2 in SERVE
    tick("srv_t1", 1'b0, 1'b0, 1'b0);
    tick("srv_t2", 1'b0, 1'b0, 1'b0);
    pulse_reset("rst_serve");
    for (int i = 0; i < SD + 2; i++) tick("after_rst", 1'b0, 1'b0, 1'b0);
    chk("after_rst_idle", 32'(STATE), 32'd0);

    // reset mid-PLAY keeps scores from changing
    tick("p_start", 1'b1, 1'b0, 1'b0);
    ride_serve("p_serve");
    pulse_reset("rst_play");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit s, l, r;
      s = ($urandom_range(0, 7) == 0) ? ~START : START;
      l = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) pulse_reset("rnd_rst");
      tick("rnd", s, l, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
